// File: rtl/eq_band_scheduler.sv
// eq_band_scheduler
// Time-multiplexes one shared band-filter datapath over NBANDS equalizer
// bands per input sample, accumulates the band results and emits one
// saturated output sample per accepted input sample.
//
// Optional feature macro: EQ_SCHED_TIMEOUT_EN
//   defined   -> a WAIT-state watchdog of TMO cycles; an unanswered band
//                contributes 0 and raises the sticky timeout flag.
//   undefined -> WAIT waits indefinitely and timeout is tied low.
`timescale 1ns/1ps

module eq_band_scheduler #(
  parameter int NBANDS = 4,
  parameter int DW     = 16,
  parameter int TMO    = 64,
  localparam int BW    = $clog2(NBANDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DW-1:0]     sample_in,
  input  logic [NBANDS-1:0] band_en,
  input  logic              ovr_clr,
  output logic              dp_start,
  output logic [BW-1:0]     dp_band,
  output logic [DW-1:0]     dp_sample,
  input  logic              dp_done,
  input  logic [DW-1:0]     dp_result,
  output logic [DW-1:0]     sample_out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun,
  output logic              timeout
);

  // Accumulator carries BW guard bits so NBANDS full-scale results cannot wrap.
  localparam int AW = DW + BW;
  localparam logic signed [AW-1:0] SAT_MAX = {{(BW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(BW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [BW-1:0]        LAST    = BW'(NBANDS - 1);

  // Reject configurations the sequencer cannot handle.
  if (NBANDS < 2 || TMO < 1) begin : g_bad_cfg
    $error("eq_band_scheduler: NBANDS must be >= 2 and TMO >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_WAIT,
    S_FIN
  } state_t;

  state_t                 state;
  logic [BW-1:0]          idx;
  logic [NBANDS-1:0]      mask;
  logic signed [AW-1:0]   acc;

  logic                   done_ok;
  logic                   band_adv;
  logic                   is_last;
  logic signed [AW-1:0]   acc_next;
  logic [DW-1:0]          sat_val;

`ifdef EQ_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0]          tmo_cnt;
  logic                   expire;
`endif

  // Band-completion decode, accumulate-next value and output saturation.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no path can infer a latch.
    // dp_start is high exactly in the first WAIT cycle, where dp_done is not yet trusted.
    done_ok  = (state == S_WAIT) && !dp_start && dp_done;
    is_last  = (idx == LAST);
    acc_next = acc + AW'($signed(dp_result));
`ifdef EQ_SCHED_TIMEOUT_EN
    // A dp_done coinciding with expiry wins; expiry only fires without one.
    expire   = (state == S_WAIT) && !done_ok && (tmo_cnt == TW'(TMO - 1));
    band_adv = done_ok || expire;
`else
    band_adv = done_ok;
`endif
    sat_val = acc[DW-1:0];
    if (acc > SAT_MAX) begin
      sat_val = {1'b0, {(DW-1){1'b1}}};
    end else if (acc < SAT_MIN) begin
      sat_val = {1'b1, {(DW-1){1'b0}}};
    end
  end

  // Band sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      mask       <= '0;
      acc        <= '0;
      dp_start   <= 1'b0;
      dp_band    <= '0;
      dp_sample  <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
`ifdef EQ_SCHED_TIMEOUT_EN
      tmo_cnt    <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch reads pre-edge values.
      dp_start  <= 1'b0;
      out_valid <= 1'b0;

      // A dropped sample sets the flag; a simultaneous clear loses.
      if (sample_valid && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (sample_valid) begin
            dp_sample <= sample_in;
            mask      <= band_en;
            acc       <= '0;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (mask[idx]) begin
            dp_start <= 1'b1;
            dp_band  <= idx;
            state    <= S_WAIT;
`ifdef EQ_SCHED_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end else if (is_last) begin
            state <= S_FIN;
          end else begin
            idx <= idx + BW'(1);
          end
        end

        S_WAIT: begin
          if (done_ok) begin
            acc <= acc_next;
          end
`ifdef EQ_SCHED_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + TW'(1);
          if (expire) begin
            timeout <= 1'b1;
          end
`endif
          if (band_adv) begin
            if (is_last) begin
              state <= S_FIN;
            end else begin
              idx   <= idx + BW'(1);
              state <= S_SCAN;
            end
          end
        end

        S_FIN: begin
          sample_out <= sat_val;
          out_valid  <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef EQ_SCHED_TIMEOUT_EN
  // Without the watchdog the datapath is trusted to answer.
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Self-checking bench for eq_band_scheduler (NBANDS=4, DW=16, datapath latency 3).
// A schedule model derives, at each accepted sample, the cycles of every
// dp_start, the out_valid cycle and the saturated sum; a per-cycle compare
// process checks the DUT against it, and directed tests pin literal values.
`timescale 1ns/1ps

module tb_eq_band_scheduler;
  localparam int NB  = 4;
  localparam int DW  = 16;
  localparam int TMO = 64;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic [3:0]  band_en = '0;
  logic        ovr_clr = 1'b0;
  logic        dp_start;
  logic [1:0]  dp_band;
  logic [15:0] dp_sample;
  logic        dp_done;
  logic [15:0] dp_result;
  logic [15:0] sample_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;
  logic        timeout;

  logic        resp_done = 1'b0;
  logic        stray_done = 1'b0;
  logic [15:0] resp_res = 16'h5A5A;

  assign dp_done   = resp_done | stray_done;
  assign dp_result = stray_done ? 16'h1111 : resp_res;

  eq_band_scheduler #(.NBANDS(NB), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .band_en(band_en), .ovr_clr(ovr_clr), .dp_start(dp_start), .dp_band(dp_band),
    .dp_sample(dp_sample), .dp_done(dp_done), .dp_result(dp_result),
    .sample_out(sample_out), .out_valid(out_valid), .busy(busy),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- datapath stand-in ----------------
  logic [15:0] res [NB];
  bit          mute [NB];
  bit          early_poke = 1'b0;
  int          done_cyc = -1;
  int          done_band = 0;

  // ---------------- schedule model ----------------
  int          m_c0 = -100;
  int          m_cout = -100;
  int          m_to_cyc = 1 << 30;
  int          m_t;
  int          m_sum;
  logic [15:0] m_exp = '0;
  logic [15:0] m_out = '0;
  logic [15:0] m_samp = '0;
  bit          m_ovr = 1'b0;
  bit          m_was_busy;
  bit          exp_start [int];
  int          exp_band [int];

  function automatic bit m_busy(input int n);
    return (n > m_c0) && (n < m_cout);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_was_busy = m_busy(cyc);
      if (sample_valid && m_was_busy) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
      if (sample_valid && !m_was_busy) begin
        m_c0   = cyc;
        m_samp = sample_in;
        m_t    = cyc + 2;
        m_sum  = 0;
        exp_start.delete();
        exp_band.delete();
        for (int b = 0; b < NB; b++) begin
          if (band_en[b]) begin
            exp_start[m_t] = 1'b1;
            exp_band[m_t]  = b;
            if (mute[b]) begin
              if (m_to_cyc > m_t + TMO) m_to_cyc = m_t + TMO;
              m_t += TMO + 1;
            end else begin
              m_sum += int'($signed(res[b]));
              m_t   += LAT + 2;
            end
          end else begin
            m_t += 1;
          end
        end
        m_cout = m_t;
        if (m_sum > 32767)       m_exp = 16'h7FFF;
        else if (m_sum < -32768) m_exp = 16'h8000;
        else                     m_exp = 16'(m_sum);
      end
    end
  end

  always @(negedge rst) begin
    m_c0 = -100;
    m_cout = -100;
    m_ovr = 1'b0;
    m_out = '0;
    m_to_cyc = 1 << 30;
    exp_start.delete();
    exp_band.delete();
  end

  // Datapath stand-in: answers LAT cycles after dp_start unless the band is muted.
  always @(negedge clk) begin
    if (dp_start) begin
      done_band = int'(dp_band);
      done_cyc  = mute[dp_band] ? -1 : cyc + LAT;
    end
  end

  always @(posedge clk) begin
    #1;
    if (cyc == done_cyc) begin
      resp_done = 1'b1;
      resp_res  = res[done_band];
    end else if (early_poke && exp_start.exists(cyc)) begin
      resp_done = 1'b1;
      resp_res  = 16'h7777;
    end else begin
      resp_done = 1'b0;
      resp_res  = 16'h5A5A;
    end
  end

  // ---------------- per-cycle compare ----------------
  int          out_cnt = 0;
  int          last_out_cyc = 0;
  logic [15:0] last_out_val = '0;
  int          starts [$];
  int          start_bands [$];

  always @(negedge clk) begin
    if (rst && chk_on) begin
      if (cyc == m_cout) m_out = m_exp;
      check("dp_start", dp_start, exp_start.exists(cyc));
      if (exp_start.exists(cyc)) begin
        check("dp_band", dp_band, exp_band[cyc]);
        check("dp_sample", dp_sample, m_samp);
      end
      check("out_valid", out_valid, cyc == m_cout);
      check("sample_out", sample_out, m_out);
      check("busy", busy, m_busy(cyc));
      check("overrun", overrun, m_ovr);
      check("timeout", timeout, cyc >= m_to_cyc);
      if (dp_start) begin
        starts.push_back(cyc);
        start_bands.push_back(int'(dp_band));
      end
      if (out_valid) begin
        out_cnt++;
        last_out_cyc = cyc;
        last_out_val = sample_out;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] s, input logic [3:0] en, output int c);
    sample_valid = 1'b1;
    sample_in    = s;
    band_en      = en;
    c            = cyc;
    tick();
    sample_valid = 1'b0;
    sample_in    = ~s;
    band_en      = ~en;
  endtask

  task automatic wait_out(input int budget, input string name);
    int n0;
    int k;
    n0 = out_cnt;
    k  = 0;
    while (out_cnt == n0 && k < budget) begin
      tick();
      k++;
    end
    check(name, out_cnt != n0, 1'b1);
  endtask

  task automatic set_res(input logic [15:0] r0, input logic [15:0] r1,
                         input logic [15:0] r2, input logic [15:0] r3);
    res[0] = r0; res[1] = r1; res[2] = r2; res[3] = r3;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_dp_start"}, dp_start, 1'b0);
    check({tag, "_dp_band"}, dp_band, 2'd0);
    check({tag, "_dp_sample"}, dp_sample, 16'h0000);
    check({tag, "_sample_out"}, sample_out, 16'h0000);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_timeout"}, timeout, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int c2;
    for (int b = 0; b < NB; b++) mute[b] = 1'b0;
    set_res(16'h0, 16'h0, 16'h0, 16'h0);

    // Reset state
    repeat (3) tick();
    check_idle_zero("reset");
    rst = 1'b1;
    chk_on = 1'b1;
    repeat (2) tick();

    // All bands, 0x0100 each
    set_res(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    starts.delete(); start_bands.delete();
    send(16'h1234, 4'hF, c);
    wait_out(60, "t1_done");
    check("t1_latency", last_out_cyc - c, 22);
    check("t1_sum", last_out_val, 16'h0400);
    check("t1_nstarts", starts.size(), 4);
    if (starts.size() == 4) begin
      check("t1_first_start", starts[0] - c, 2);
      check("t1_last_start", starts[3] - c, 17);
      check("t1_band0", start_bands[0], 0);
      check("t1_band3", start_bands[3], 3);
    end
    check("t1_dp_sample", dp_sample, 16'h1234);
    repeat (2) tick();

    // Bands 1 and 3 at -32768 -> negative saturation
    set_res(16'h1234, 16'h8000, 16'h1234, 16'h8000);
    starts.delete(); start_bands.delete();
    send(16'h0777, 4'b1010, c);
    wait_out(60, "t2_done");
    check("t2_nstarts", starts.size(), 2);
    check("t2_latency", last_out_cyc - c, 14);
    check("t2_sum", last_out_val, 16'h8000);
    repeat (2) tick();

    // Positive saturation, then all bands disabled
    set_res(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    send(16'h0001, 4'hF, c);
    wait_out(60, "t3_done");
    check("t3_sum", last_out_val, 16'h7FFF);
    starts.delete();
    send(16'h0002, 4'h0, c);
    wait_out(20, "t3b_done");
    check("t3b_latency", last_out_cyc - c, 6);
    check("t3b_sum", last_out_val, 16'h0000);
    check("t3b_nstarts", starts.size(), 0);
    repeat (2) tick();

    // Mixed signs, band 3 disabled
    set_res(16'h7000, 16'hF000, 16'h0123, 16'hFFFF);
    send(16'h5555, 4'b0111, c);
    wait_out(60, "t4_done");
    check("t4_latency", last_out_cyc - c, 18);
    check("t4_sum", last_out_val, 16'h6123);
    repeat (2) tick();

    // Overrun during WAIT; in-progress result unaffected
    set_res(16'h0010, 16'h0010, 16'h0010, 16'h0010);
    send(16'h0A0A, 4'hF, c);
    repeat (2) tick();
    send(16'h0B0B, 4'h1, c2);
    check("ovr_set", overrun, 1'b1);
    wait_out(60, "t5_done");
    check("ovr_result", last_out_val, 16'h0040);
    send(16'h0C0C, 4'hF, c);
    tick();
    ovr_clr = 1'b1;
    send(16'h0D0D, 4'h2, c2);
    ovr_clr = 1'b0;
    check("ovr_set_wins", overrun, 1'b1);
    wait_out(60, "t5b_done");
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_cleared", overrun, 1'b0);

    // dp_done in the dp_start cycle must be ignored
    early_poke = 1'b1;
    send(16'h0E0E, 4'hF, c);
    wait_out(60, "t6_done");
    early_poke = 1'b0;
    check("early_done_ignored", last_out_val, 16'h0040);
    repeat (2) tick();

    // New sample accepted in the out_valid cycle
    set_res(16'h0055, 16'h0, 16'h0, 16'h0);
    send(16'h1111, 4'h0, c);
    while (cyc < c + 6) tick();
    check("b2b_busy_low", busy, 1'b0);
    send(16'h2222, 4'h1, c2);
    wait_out(30, "t7_done");
    check("b2b_latency", last_out_cyc - c2, 10);
    check("b2b_sum", last_out_val, 16'h0055);
    check("b2b_no_ovr", overrun, 1'b0);

    // Stray dp_done while idle
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    set_res(16'h0010, 16'h0010, 16'h0010, 16'h0010);
    send(16'h2A2A, 4'hF, c);
    wait_out(60, "t8_done");
    check("stray_ignored", last_out_val, 16'h0040);
    repeat (2) tick();

    // Reset during WAIT with a late dp_done afterwards
    set_res(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    send(16'h3333, 4'hF, c);
    send(16'h3434, 4'hF, c2);
    check("rst_pre_start", dp_start, 1'b1);
    #6;
    rst = 1'b0;
    #1;
    check_idle_zero("rst_mid");
    tick();
    rst = 1'b1;
    while (cyc < c + 9) tick();
    check("rst_late_done_idle", busy, 1'b0);
    starts.delete(); start_bands.delete();
    send(16'h4444, 4'hF, c);
    wait_out(60, "t9_done");
    check("rst_clean_latency", last_out_cyc - c, 22);
    check("rst_clean_sum", last_out_val, 16'h0400);
    check("rst_clean_nstarts", starts.size(), 4);
    check("rst_clean_sample", dp_sample, 16'h4444);
    repeat (2) tick();

`ifdef EQ_SCHED_TIMEOUT_EN
    // Band 2 never answers
    set_res(16'h0100, 16'h0200, 16'h0F00, 16'h0300);
    mute[2] = 1'b1;
    send(16'h5A5A, 4'hF, c);
    wait_out(300, "tmo_done");
    mute[2] = 1'b0;
    check("tmo_latency", last_out_cyc - c, 82);
    check("tmo_sum", last_out_val, 16'h0600);
    check("tmo_flag", timeout, 1'b1);
    repeat (2) tick();
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eq_band_scheduler.md
# eq_band_scheduler

Sequences the equalizer's single shared band-filter datapath across all frequency bands for each incoming audio sample. Sums the per-band results with saturation and presents one equalized output sample per input sample. Sits between the sample source and the output stage. Owns the start/done handshake to the filter datapath so only one band is computed at a time.

## Interface
- NBANDS, 4: number of equalizer bands (≥2); BW = $clog2(NBANDS)
- DW, 16: signed sample width
- TMO, 64: WAIT-state timeout in cycles (used only with EQ_SCHED_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- sample_valid  in  1  one-cycle strobe: new input sample
- sample_in  in  DW  signed input sample, valid with sample_valid
- band_en  in  NBANDS  per-band enable mask, latched with sample_valid
- ovr_clr  in  1  clears overrun flag
- dp_start  out  1  one-cycle pulse: datapath begins band dp_band
- dp_band  out  BW  band index being computed
- dp_sample  out  DW  latched input sample for the datapath
- dp_done  in  1  one-cycle pulse: dp_result valid
- dp_result  in  DW  signed band result
- sample_out  out  DW  signed saturated sum of enabled bands
- out_valid  out  1  one-cycle pulse: sample_out updated
- busy  out  1  high whenever state ≠ IDLE
- overrun  out  1  sticky: sample_valid arrived while busy
- timeout  out  1  sticky: datapath failed to answer (macro only)

## Operation
- Reset (rst=0, asynchronous) forces: state IDLE, index 0, accumulator 0, every output 0. dp_start drops immediately.
- IDLE: on sample_valid, latch sample_in→dp_sample and band_en→mask, clear acc, idx←0, go to SCAN.
- SCAN (one cycle per index):
  - mask[idx]=1: register dp_start=1 and dp_band=idx, go to WAIT.
  - Otherwise, if idx=NBANDS−1 go to FIN, else idx←idx+1 and stay in SCAN.
- WAIT: dp_start is high only in the first WAIT cycle. dp_done is ignored in that cycle and accepted from the next one.
  - On dp_done: acc ← acc + sign-extended dp_result. Then, if idx=NBANDS−1 go to FIN, else idx←idx+1 and go to SCAN.
- FIN: saturate acc to DW bits and register it to sample_out. out_valid is high in the following cycle. Return to IDLE.
- Arithmetic: acc is DW+BW bits signed. Saturation clamps to [−2^(DW−1), 2^(DW−1)−1]. sample_out holds its value between updates.
- All bands disabled: the block still produces out_valid, with sample_out=0.
- sample_valid while busy: the sample is dropped and overrun←1. The in-progress sample is unaffected.
- overrun clears on ovr_clr=1. If set and clear occur in the same cycle, set wins.
- dp_done outside WAIT is ignored.
- busy is high from the cycle after sample_valid through FIN. It is low in the cycle where out_valid is high, so a new sample_valid is accepted in that cycle.

## Timing
- Datapath latency L = cycles from dp_start to dp_done (L≥1).
- Each enabled band costs L+2 cycles. Each disabled band costs 1 cycle.
- out_valid arrives 2 + Σ(per-band cost) cycles after sample_valid.
  - NBANDS=4, L=3, all enabled: sample_valid at cycle 0 → dp_start at cycles 2, 7, 12, 17 → out_valid at cycle 22.
  - All disabled: out_valid at cycle 6.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- EQ_SCHED_TIMEOUT_EN defined: a counter runs in WAIT.
  - If TMO cycles pass without dp_done, the band contributes 0, timeout←1 (sticky, cleared only by reset), and the FSM proceeds as if dp_done had arrived.
  - A dp_done in the same cycle as expiry is accepted normally and timeout is not set.
- EQ_SCHED_TIMEOUT_EN undefined: WAIT waits indefinitely for dp_done, timeout is tied to 0, and TMO is unused.

## Test plan
- All 4 bands enabled, L=3, dp_result=0x0100 each, sample_in=0x1234 → dp_band 0,1,2,3 in order, dp_sample=0x1234, out_valid at cycle 22, sample_out=0x0400.
- band_en=4'b1010, dp_result=0x8000 on bands 1 and 3 → only two dp_start pulses, sample_out=0x8000 (negative saturation).
- All enabled, dp_result=0x4000 each → sum 0x10000 saturates to sample_out=0x7FFF. Then band_en=0 → out_valid at cycle 6 with sample_out=0x0000.
- Second sample_valid during WAIT → overrun=1, first result unchanged. ovr_clr held while another overrun occurs → overrun stays 1.
- rst pulled low during WAIT → all outputs 0 immediately. A late dp_done is ignored and the next sample_valid runs a clean sequence.
- With EQ_SCHED_TIMEOUT_EN, TMO=64, band 2 never answers → timeout=1 at its 64th WAIT cycle, sample_out = sum of bands 0, 1, 3.
